// File: rtl/sha256_pkg.sv
// Shared sizing constants and FSM encoding for the SHA-256 message-schedule sequencer.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_BEATS = 8;
  localparam int SCH_BEATS = 32;
  localparam int RND_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DRAIN
  } sched_state_t;

endpackage

// File: rtl/sched_vpipe.sv
// DEPTH-stage valid/round/last tag pipeline shadowing the schedule datapath; shifts only on en_i.
// Latency DEPTH advances; holds its contents while en_i is low.
module sched_vpipe
  import sha256_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [RND_W-1:0] round_i,
  input  logic             last_i,
  output logic             vld_o,
  output logic [RND_W-1:0] round_o,
  output logic             last_o
);

  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0]            r_last;
  logic [DEPTH-1:0][RND_W-1:0] r_round;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_vld   <= '0;
      r_last  <= '0;
      r_round <= '0;
    end else if (en_i) begin
      r_vld[0]   <= vld_i;
      r_last[0]  <= last_i;
      r_round[0] <= round_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_last[i]  <= r_last[i-1];
        r_round[i] <= r_round[i-1];
      end
    end
  end

  assign vld_o   = r_vld[DEPTH-1];
  assign round_o = r_round[DEPTH-1];
  assign last_o  = r_last[DEPTH-1];

endmodule

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads 8 input beats, expands to 32 schedule beats, tags rounds.
// Pairs appear PIPE_LAT advances after entry; input gaps and w_ready_i low both freeze the datapath enable.
module sha256_sched_ctrl #(
  parameter int WORD_W    = sha256_pkg::WORD_W,
  parameter int PIPE_LAT  = 2,
  parameter int BLK_BEATS = sha256_pkg::BLK_BEATS,
  parameter int SCH_BEATS = sha256_pkg::SCH_BEATS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                blk_valid_i,
  output logic                blk_ready_o,
  input  logic [2*WORD_W-1:0] blk_data_i,
  input  logic                blk_last_i,
  input  logic [2*WORD_W-1:0] fb_data_i,
  output logic                dp_en_o,
  output logic                sched_sel_o,
  output logic [2*WORD_W-1:0] sched_data_o,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [5:0]          round_o,
  output logic                last_o,
  output logic                blk_done_o,
  output logic                busy_o
);

  import sha256_pkg::*;

  localparam int                 CNT_W    = $clog2(SCH_BEATS);
  localparam logic [CNT_W-1:0]   LOAD_END = CNT_W'(BLK_BEATS - 1);
  localparam logic [CNT_W-1:0]   SCH_END  = CNT_W'(SCH_BEATS - 1);
  localparam logic [RND_W-1:0]   LAST_RND = RND_W'(2 * SCH_BEATS - 2);

  sched_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic              r_last_flag, w_last_flag_nxt;
  logic              r_taken;
  logic              r_done;
  logic              w_out_free;
  logic              w_adv;
  logic              w_hs;
  logic              w_stage_vld;
  logic              w_stage_last;
  logic [RND_W-1:0]  w_stage_round;
  logic              w_pipe_vld;
  logic              w_pipe_last;
  logic [RND_W-1:0]  w_pipe_round;

  // A pair consumed while the datapath is held (input gap) must not be presented a second time.
  assign w_valid_o     = w_pipe_vld && !r_taken;
  assign w_hs          = w_valid_o && w_ready_i;
  assign w_out_free    = !w_valid_o || w_ready_i;
  assign w_stage_round = RND_W'({r_beat_cnt, 1'b0});
  assign w_stage_last  = r_last_flag && (r_beat_cnt == SCH_END);

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_last_flag_nxt = r_last_flag;
    blk_ready_o     = 1'b0;
    w_adv           = 1'b0;
    w_stage_vld     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        blk_ready_o = w_out_free;
        if (blk_valid_i && w_out_free) begin
          w_adv           = 1'b1;
          w_stage_vld     = 1'b1;
          w_beat_cnt_nxt  = CNT_W'(1);
          w_last_flag_nxt = blk_last_i;
          w_state_nxt     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        blk_ready_o = w_out_free;
        if (blk_valid_i && w_out_free) begin
          w_adv          = 1'b1;
          w_stage_vld    = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          if (r_beat_cnt == LOAD_END) w_state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_adv       = w_out_free;
        w_stage_vld = 1'b1;
        if (w_out_free) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          if (r_beat_cnt == SCH_END) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_adv = w_out_free;
        if (w_hs && (w_pipe_round == LAST_RND)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst_i) begin
      blk_ready_o = 1'b0;
      w_adv       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_last_flag <= 1'b0;
      r_taken     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_last_flag <= w_last_flag_nxt;
      r_done      <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
      if (w_adv)     r_taken <= 1'b0;
      else if (w_hs) r_taken <= 1'b1;
    end
  end

  sched_vpipe #(
    .DEPTH (PIPE_LAT)
  ) u_vpipe (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .en_i    (w_adv),
    .vld_i   (w_stage_vld),
    .round_i (w_stage_round),
    .last_i  (w_stage_last),
    .vld_o   (w_pipe_vld),
    .round_o (w_pipe_round),
    .last_o  (w_pipe_last)
  );

  assign dp_en_o      = w_adv;
  assign sched_sel_o  = (r_state == ST_EXPAND) || (r_state == ST_DRAIN);
  assign sched_data_o = sched_sel_o ? fb_data_i : blk_data_i;
  assign round_o      = w_pipe_round;
  assign last_o       = w_pipe_last && w_valid_o;
  assign blk_done_o   = r_done;
  assign busy_o       = (r_state != ST_IDLE);

endmodule
